pixel_fb_writer: RTL and testbench

- Consumer end of the drawer pixel stream (x, y, colour, writeEn, enable/done handshake) used by the hook, rope and object draw FSMs.
- Kicks a drawer, captures every pixel it emits into a small FIFO, converts (x,y) to a linear framebuffer address and writes the framebuffer through a stallable write port.
- Reports pass completion only after the FIFO has fully drained.
- Sits between the draw FSMs and the VGA framebuffer RAM write port.

---
 rtl/gm_video_pkg.sv | 28 ++
 rtl/pixel_fifo.sv | 59 +++++
 rtl/pixel_fb_writer.sv | 156 +++++++++++++++
 tb/tb_pixel_fb_writer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gm_video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gm_video_pkg
// Brief    : Shared video constants, pixel-entry type and writer FSM encoding.
// Revision : 1.0
// ============================================================================
package gm_video_pkg;

    localparam int unsigned SCREEN_W  = 320;
    localparam int unsigned SCREEN_H  = 240;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned COLOR_W   = 12;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [COLOR_W-1:0]   color;
    } pixel_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KICK    = 3'd1,
        ST_COLLECT = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } fbw_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo
// Brief    : First-word fall-through synchronous FIFO; a push while full is
//            accepted when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module pixel_fifo #(
    parameter int unsigned WIDTH = 29,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fb_writer
// Brief    : Kicks a drawer, queues its pixels and writes them to the
//            framebuffer; signals completion once the queue has drained.
// Revision : 1.0
// ============================================================================
module pixel_fb_writer
    import gm_video_pkg::*;
#(
    parameter int unsigned SCREEN_W   = gm_video_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H   = gm_video_pkg::SCREEN_H,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = gm_video_pkg::FB_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              draw_enable,
    input  logic              draw_done,
    input  logic [8:0]        pix_x,
    input  logic [7:0]        pix_y,
    input  logic [11:0]       pix_color,
    input  logic              pix_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic              busy,
    output logic              pass_done,
    output logic              overflow,
    output logic [7:0]        clip_count
);

    localparam int unsigned ENTRY_W = ADDR_W + COLOR_W;

    fbw_state_t         r_state;
    fbw_state_t         w_next;
    logic [ADDR_W-1:0]  w_x_ext;
    logic [ADDR_W-1:0]  w_y_ext;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_accept;
    logic               w_clip;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [ENTRY_W-1:0] w_head;
    logic               r_overflow;
    logic [7:0]         r_clip_count;

    assign w_x_ext = ADDR_W'(pix_x);
    assign w_y_ext = ADDR_W'(pix_y);

    // The default width factors as 256+64, so two shifts replace a multiplier.
    generate
        if (SCREEN_W == 320) begin : g_addr_shift
            assign w_addr = (w_y_ext << 8) + (w_y_ext << 6) + w_x_ext;
        end else begin : g_addr_mul
            localparam logic [ADDR_W-1:0] C_SCREEN_W = ADDR_W'(SCREEN_W);
            assign w_addr = (w_y_ext * C_SCREEN_W) + w_x_ext;
        end
    endgenerate

    assign w_clip   = (32'(pix_x) >= SCREEN_W) || (32'(pix_y) >= SCREEN_H);
    assign w_accept = (r_state == ST_COLLECT) && pix_we;
    assign w_push   = w_accept && !w_clip;
    assign w_drop   = w_push && w_fifo_full && !w_pop;

    assign fb_we = !w_fifo_empty && ((r_state == ST_COLLECT) || (r_state == ST_FLUSH));
    assign w_pop = fb_we && fb_ready;
    assign {fb_addr, fb_data} = w_head;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data ({w_addr, pix_color}),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        draw_enable = 1'b0;
        pass_done   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = ST_KICK;
                end
            end
            ST_KICK: begin
                draw_enable = 1'b1;
                w_next      = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (draw_done) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_fifo_empty) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                pass_done = 1'b1;
                w_next    = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    // Pass statistics live until the next start so the owner can read them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_clip_count <= 8'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_overflow   <= 1'b0;
            r_clip_count <= 8'd0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept && w_clip && (r_clip_count != 8'hFF)) begin
                r_clip_count <= r_clip_count + 8'd1;
            end
        end
    end

    assign overflow   = r_overflow;
    assign clip_count = r_clip_count;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_fb_writer
// Brief    : Directed self-checking bench for pixel_fb_writer.
// Revision : 1.0
// ============================================================================
module tb_pixel_fb_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        draw_enable;
    logic        draw_done = 1'b0;
    logic [8:0]  pix_x = '0;
    logic [7:0]  pix_y = '0;
    logic [11:0] pix_color = '0;
    logic        pix_we = 1'b0;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b1;
    logic        busy;
    logic        pass_done;
    logic        overflow;
    logic [7:0]  clip_count;

    int n_checks = 0;
    int n_errors = 0;
    int pd_count = 0;
    int writes_at_done = 0;
    int pd_before;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    pixel_fb_writer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .draw_enable (draw_enable),
        .draw_done   (draw_done),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .pix_we      (pix_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .fb_ready    (fb_ready),
        .busy        (busy),
        .pass_done   (pass_done),
        .overflow    (overflow),
        .clip_count  (clip_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (fb_we && fb_ready) begin
            wa.push_back(32'(fb_addr));
            wd.push_back(32'(fb_data));
        end
        if (pass_done) begin
            pd_count++;
            writes_at_done = wa.size();
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] get_a(input int i);
        return (wa.size() > i) ? wa[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] get_d(input int i);
        return (wd.size() > i) ? wd[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic start_pass();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("kick_enable", 32'(draw_enable), 32'd1);
        tick();
    endtask

    task automatic send_pix(input int x, input int y, input int c);
        pix_x     = 9'(x);
        pix_y     = 8'(y);
        pix_color = 12'(c);
        pix_we    = 1'b1;
        tick();
        pix_we    = 1'b0;
    endtask

    task automatic end_draw();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!pass_done && i < budget) begin
            tick();
            i++;
        end
        check("done_seen", 32'(pass_done), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_draw_enable", 32'(draw_enable), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pass_done", 32'(pass_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_clip", 32'(clip_count), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Basic pass
        clear_log();
        pd_before = pd_count;
        start_pass();
        check("basic_busy", 32'(busy), 32'd1);
        send_pix(10, 2, 'hBBB);
        send_pix(0, 0, 'h123);
        end_draw();
        wait_done(50);
        check("basic_nwr", 32'(wa.size()), 32'd2);
        check("basic_a0", get_a(0), 32'd650);
        check("basic_d0", get_d(0), 32'hBBB);
        check("basic_a1", get_a(1), 32'd0);
        check("basic_d1", get_d(1), 32'h123);
        check("basic_pd", 32'(pd_count - pd_before), 32'd1);
        check("basic_idle", 32'(busy), 32'd0);

        // Bounds
        clear_log();
        start_pass();
        send_pix(319, 239, 'hABC);
        send_pix(320, 5, 'h111);
        send_pix(5, 240, 'h222);
        end_draw();
        wait_done(50);
        check("bnd_nwr", 32'(wa.size()), 32'd1);
        check("bnd_a0", get_a(0), 32'd76799);
        check("bnd_d0", get_d(0), 32'hABC);
        check("bnd_clip", 32'(clip_count), 32'd2);
        check("bnd_ovf", 32'(overflow), 32'd0);

        // Backpressure with overflow
        clear_log();
        pd_before = pd_count;
        fb_ready = 1'b0;
        start_pass();
        for (int x = 1; x <= 16; x++) send_pix(x, 0, x);
        check("bp_no_ovf_yet", 32'(overflow), 32'd0);
        send_pix(99, 0, 'h099);
        check("bp_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        end_draw();
        for (int i = 0; i < 4; i++) tick();
        check("bp_nwr_stalled", 32'(wa.size()), 32'd0);
        check("bp_pd_stalled", 32'(pd_count - pd_before), 32'd0);
        fb_ready = 1'b1;
        wait_done(100);
        check("bp_nwr", 32'(wa.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("bp_a%0d", i), get_a(i), 32'(i + 1));
            check($sformatf("bp_d%0d", i), get_d(i), 32'(i + 1));
        end
        check("bp_ovf_sticky", 32'(overflow), 32'd1);
        check("bp_pd", 32'(pd_count - pd_before), 32'd1);

        // Last pixel coincides with draw_done
        clear_log();
        start_pass();
        check("last_ovf_cleared", 32'(overflow), 32'd0);
        pix_x = 9'd7; pix_y = 8'd1; pix_color = 12'h777; pix_we = 1'b1;
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        pix_x = 9'd8; pix_color = 12'h888;
        tick();
        pix_we = 1'b0;
        wait_done(50);
        check("last_nwr", 32'(wa.size()), 32'd1);
        check("last_a0", get_a(0), 32'd327);
        check("last_d0", get_d(0), 32'h777);
        check("last_before_done", 32'(writes_at_done), 32'd1);

        // Stall in FLUSH
        clear_log();
        pd_before = pd_count;
        fb_ready = 1'b0;
        start_pass();
        for (int x = 20; x < 24; x++) send_pix(x, 3, 'h300 + x);
        end_draw();
        for (int i = 0; i < 10; i++) tick();
        check("fl_busy", 32'(busy), 32'd1);
        check("fl_no_pd", 32'(pd_count - pd_before), 32'd0);
        check("fl_we_held", 32'(fb_we), 32'd1);
        check("fl_addr_held", 32'(fb_addr), 32'd980);
        check("fl_data_held", 32'(fb_data), 32'h314);
        fb_ready = 1'b1;
        wait_done(50);
        check("fl_nwr", 32'(wa.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("fl_a%0d", i), get_a(i), 32'(980 + i));
        check("fl_pd", 32'(pd_count - pd_before), 32'd1);

        // Reset during FLUSH with queued pixels
        fb_ready = 1'b0;
        start_pass();
        send_pix(1, 1, 'h001);
        send_pix(2, 1, 'h002);
        send_pix(3, 1, 'h003);
        end_draw();
        check("rm_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_fb_we", 32'(fb_we), 32'd0);
        check("rm_enable", 32'(draw_enable), 32'd0);
        check("rm_pass_done", 32'(pass_done), 32'd0);
        check("rm_clip", 32'(clip_count), 32'd0);
        tick();
        reset = 1'b0;
        fb_ready = 1'b1;
        clear_log();
        pd_before = pd_count;
        start_pass();
        end_draw();
        wait_done(50);
        check("rm_no_stale", 32'(wa.size()), 32'd0);
        check("rm_pd", 32'(pd_count - pd_before), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
